bam_mult_pipe: RTL and testbench
================================

// Module: bam_mult_pipe
// PURPOSE
//  Parametrised, pipelined broken-array approximate multiplier (BAM) with per-operation runtime
//  vertical breaking level (VBL) and valid/ready handshakes on both sides.
//  Generalises the fixed 4x4 combinational BAM to any WIDTH, and is the MAC-front multiplier for
//  APTPU PEs. Sustains one product per cycle under backpressure.
// PARAMETERS
//  WIDTH    8    unsigned operand width (>=2); product width is 2*WIDTH
//  VBL_W    4    width of in_vbl; must satisfy 2**VBL_W >= 2*WIDTH
//  VBL_MAX  7    largest VBL honoured; larger requests are clamped to VBL_MAX (<= 2*WIDTH-1)
//  TAG_W    4    sideband tag width, carried unchanged alongside each operation
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  in_a       in   WIDTH    multiplicand, unsigned
//  in_b       in   WIDTH    multiplier, unsigned
//  in_vbl     in   VBL_W    breaking level for this beat
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        result beat valid
//  out_ready  in   1        downstream accepts result
//  out_r      out  2*WIDTH  approximate product
//  out_tag    out  TAG_W    tag of the beat in out_r
// BEHAVIOUR
//  - Arithmetic: v = min(in_vbl, VBL_MAX). Partial-product bit a[i]&b[j] is dropped iff i+j < v.
//    out_r = sum of the surviving bits << (i+j), mod 2**(2*WIDTH). v=0 gives the exact product.
//  - Pipeline, 3 stages, each with its own valid bit:
//    S1 registers the masked partial-product rows plus the tag.
//    S2 registers the carry-save reduction to two rows (sum and carry).
//    S3 registers the final carry-propagate add and drives out_r/out_tag.
//  - Latency 3 cycles from the in_valid&&in_ready edge to out_valid, provided nothing stalls.
//  - Handshakes: a beat transfers on an edge where valid&&ready.
//    Stage k advances when it is empty or stage k+1 advances; S3 advances when out_ready or !out_valid.
//    in_ready = S1 advances this cycle. in_ready may depend on out_ready combinationally.
//  - Once out_valid is high, it and out_r/out_tag hold stable until the beat is accepted.
//    Beats are never dropped, duplicated or reordered.
//  - The VBL is captured per beat: mixed VBLs in flight each get their own VBL.
//  - Full pipeline: with out_ready=0 the block holds 3 beats and in_ready=0.
//    On the first out_ready=1 cycle, in_ready=1 in the same cycle, so there is no bubble.
//  - Empty pipeline: out_valid=0. out_r/out_tag hold their last value and are don't-care.
//  - Reset (async assert, synchronous release): all stage valids clear, so out_valid=0 and
//    in_ready=1 after release. out_r=0 and out_tag=0. Beats in flight at reset are discarded.
//  - Data registers need no reset, except the S3 output registers.
// STRUCTURE
//  - Shared package bam_pkg holds:
//    localparams PROD_W = 2*WIDTH and the CSA depth function.
//    function bam_ref(a,b,v), the golden model used by both RTL assertions and the bench.
//    function vbl_clamp.
//  - One sub-module: bam_csa_reduce. It is a combinational Wallace/Dadda reduction of WIDTH masked
//    rows to sum/carry rows of PROD_W bits, placed between S1 and S2.
//  - This file holds the PP mask generation, the stage registers, handshake logic and the final adder.
// TESTING
//  1. WIDTH=4, v=0, a=15 b=15 -> out_r=225 three cycles after accept; a=0 b=9 -> 0.
//  2. WIDTH=4, v=3, a=15 b=15 -> out_r=208. Dropped terms: col0 1 + col1 2*2 + col2 3*4 = 17.
//     in_vbl=15 with VBL_MAX=7 -> clamp to 7 -> out_r=0.
//  3. WIDTH=8, back-to-back random beats with v in 0..7 and out_ready=1:
//     one result per cycle, every out_r == bam_ref, tags returned in order.
//  4. Backpressure: issue 6 beats while out_ready=0 -> in_ready falls after 3 accepts and
//     out_r holds stable. Raise out_ready -> all 6 results emerge in order, none lost.
//  5. Random toggling of in_valid/out_ready over 10k cycles: scoreboard against bam_ref.
//     Assert no valid-drop-without-ready and stable data during a stall.
//  6. Assert rst_n mid-stream with 3 beats in flight -> out_valid=0 immediately (async).
//     After release, in_ready=1 and the next beat a=5 b=7 v=0 returns 35 with no stale output.

Source files
------------

// File: rtl/bam_pkg.sv
// Shared definitions for the broken-array approximate multiplier: product width,
// CSA depth, VBL clamping and the bit-level golden model.
package bam_pkg;

    localparam int BAM_DEF_WIDTH  = 8;
    localparam int BAM_DEF_PROD_W = 2 * BAM_DEF_WIDTH;

    // Product width for a given operand width.
    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // Number of 3:2 levels a Wallace tree needs to bring `rows` rows down to two.
    function automatic int csa_depth(input int rows);
        int n;
        int d;
        n = rows;
        d = 0;
        while (n > 2) begin
            n = n - n / 3;
            d++;
        end
        return d;
    endfunction

    // Requests above vmax are honoured as vmax.
    function automatic int vbl_clamp(input int v, input int vmax);
        return (v > vmax) ? vmax : v;
    endfunction

    // Golden model: sum every partial-product bit a[i]&b[j] whose column i+j is
    // at or above the (already clamped) breaking level v. Caller truncates to 2*width.
    function automatic logic [63:0] bam_ref(input logic [31:0] a, input logic [31:0] b,
                                            input int v, input int width);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < width; i++) begin
            for (int j = 0; j < width; j++) begin
                if (a[i] && b[j] && ((i + j) >= v)) begin
                    acc = acc + (64'd1 << (i + j));
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bam_csa_reduce.sv
// Combinational carry-save reduction of WIDTH masked partial-product rows to a
// redundant sum/carry pair whose modular sum equals the sum of all rows.
module bam_csa_reduce #(
    parameter int WIDTH  = 8,
    parameter int PROD_W = 16
) (
    input  logic [WIDTH-1:0][PROD_W-1:0] rows_i,
    output logic [PROD_W-1:0]            sum_o,
    output logic [PROD_W-1:0]            carry_o
);

    logic [PROD_W-1:0] sum_acc;
    logic [PROD_W-1:0] carry_acc;
    logic [PROD_W-1:0] maj;

    // Fold each further row into the running sum/carry with a row of full adders.
    always_comb begin
        sum_acc   = rows_i[0];
        carry_acc = '0;
        maj       = '0;
        for (int k = 1; k < WIDTH; k++) begin
            maj       = (sum_acc & carry_acc) | (sum_acc & rows_i[k]) | (carry_acc & rows_i[k]);
            sum_acc   = sum_acc ^ carry_acc ^ rows_i[k];
            carry_acc = maj << 1;
        end
    end

    assign sum_o   = sum_acc;
    assign carry_o = carry_acc;

endmodule

// File: rtl/bam_mult_pipe.sv
// Three-stage pipelined broken-array approximate multiplier with a per-beat
// breaking level. Handshake: a beat moves on any rising edge where valid && ready;
// each stage takes new contents when it is empty or its successor is moving, so
// a full pipe refills in the same cycle the output is accepted.
module bam_mult_pipe
    import bam_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int VBL_W   = 4,
    parameter int VBL_MAX = 7,
    parameter int TAG_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [VBL_W-1:0]      in_vbl,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out_r,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int PROD_W = prod_w(WIDTH);

    logic                          s1_v_q, s2_v_q, s3_v_q;
    logic                          s1_adv, s2_adv, s3_adv;
    logic [WIDTH-1:0][PROD_W-1:0]  pp_d;
    logic [WIDTH-1:0][PROD_W-1:0]  s1_rows_q;
    logic [TAG_W-1:0]              s1_tag_q;
    logic [PROD_W-1:0]             csa_sum, csa_carry;
    logic [PROD_W-1:0]             s2_sum_q, s2_carry_q;
    logic [TAG_W-1:0]              s2_tag_q;
    logic [PROD_W-1:0]             out_r_q, out_r_d;
    logic [TAG_W-1:0]              out_tag_q;
    int                            v_eff;

    // Advance chain: the output stage frees up first, and readiness ripples back to the input.
    assign s3_adv   = out_ready || !s3_v_q;
    assign s2_adv   = s3_adv || !s2_v_q;
    assign s1_adv   = s2_adv || !s1_v_q;
    assign in_ready = s1_adv;

    // Partial-product rows with every bit below the clamped breaking column forced to zero.
    always_comb begin
        pp_d  = '0;
        v_eff = vbl_clamp(int'(in_vbl), VBL_MAX);
        for (int j = 0; j < WIDTH; j++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((i + j) >= v_eff) begin
                    pp_d[j][i+j] = in_a[i] & in_b[j];
                end
            end
        end
    end

    bam_csa_reduce #(
        .WIDTH  (WIDTH),
        .PROD_W (PROD_W)
    ) u_csa (
        .rows_i  (s1_rows_q),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    assign out_r_d = s2_sum_q + s2_carry_q;

    // Stage occupancy; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
        end else begin
            if (s1_adv) s1_v_q <= in_valid;
            if (s2_adv) s2_v_q <= s1_v_q;
            if (s3_adv) s3_v_q <= s2_v_q;
        end
    end

    // Stage 1 and stage 2 payload; only loaded when a real beat moves in.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_rows_q <= pp_d;
            s1_tag_q  <= in_tag;
        end
        if (s2_adv && s1_v_q) begin
            s2_sum_q   <= csa_sum;
            s2_carry_q <= csa_carry;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // Output stage: final carry-propagate add, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r_q   <= '0;
            out_tag_q <= '0;
        end else if (s3_adv && s2_v_q) begin
            out_r_q   <= out_r_d;
            out_tag_q <= s2_tag_q;
        end
    end

    assign out_valid = s3_v_q;
    assign out_r     = out_r_q;
    assign out_tag   = out_tag_q;

    // A presented result must stay put until it is taken.
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_r) && $stable(out_tag)));

endmodule

// File: tb/tb_bam_mult_pipe.sv
module tb_bam_mult_pipe;
    import bam_pkg::*;

    localparam int WIDTH   = 8;
    localparam int VBL_W   = 4;
    localparam int VBL_MAX = 7;
    localparam int TAG_W   = 4;
    localparam int PROD_W  = 2 * WIDTH;
    localparam int EXP_W   = TAG_W + PROD_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic [VBL_W-1:0]   in_vbl = '0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PROD_W-1:0]  out_r;
    logic [TAG_W-1:0]   out_tag;

    logic [EXP_W-1:0]   exp_q[$];
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 run_len = 0;
    int                 max_run = 0;
    bit                 prev_stall = 1'b0;
    logic [PROD_W-1:0]  prev_r = '0;
    logic [TAG_W-1:0]   prev_tag = '0;

    bam_mult_pipe #(
        .WIDTH   (WIDTH),
        .VBL_W   (VBL_W),
        .VBL_MAX (VBL_MAX),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_vbl    (in_vbl),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [PROD_W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [VBL_W-1:0] v);
        logic [63:0] full;
        full = bam_ref(32'(a), 32'(b), vbl_clamp(int'(v), VBL_MAX), WIDTH);
        return full[PROD_W-1:0];
    endfunction

    // Inputs must already be presented; waits (bounded) for the accept edge and books the result.
    task automatic wait_accept(input logic [EXP_W-1:0] e);
        int  k;
        bit  done;
        k = 0;
        done = 1'b0;
        while (!done && k < 100) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 100 cycles");
        end
    endtask

    // Driver: present one beat with a hand-supplied expected product.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [VBL_W-1:0] v, input logic [TAG_W-1:0] tag,
                        input logic [PROD_W-1:0] expv);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_vbl   = v;
        in_tag   = tag;
        wait_accept({tag, expv});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (!out_valid || out_r !== prev_r || out_tag !== prev_tag) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b r=%0d tag=%0d expected v=1 r=%0d tag=%0d",
                             out_valid, out_r, out_tag, prev_r, prev_tag);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got r=%0d tag=%0d expected no output", out_r, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_tag, out_r} !== e) begin
                        n_err++;
                        $display("FAIL result: got r=%0d tag=%0d expected r=%0d tag=%0d",
                                 out_r, out_tag, e[PROD_W-1:0], e[EXP_W-1:PROD_W]);
                    end
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_r     = out_r;
            prev_tag   = out_tag;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        bit pend;
        logic [WIDTH-1:0] ra, rb;
        logic [VBL_W-1:0] rv;
        logic [TAG_W-1:0] rt;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_r", 32'(out_r), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);

        // Exact products and latency.
        out_ready = 1'b1;
        send(8'd15, 8'd15, 4'd0, 4'd1, 16'd225);
        idle();
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            if (!out_valid) lat++;
        end
        check("latency", 32'(lat), 32'd3);
        drain();
        send(8'd0, 8'd9, 4'd0, 4'd2, 16'd0);
        send(8'd5, 8'd7, 4'd0, 4'd3, 16'd35);
        send(8'd200, 8'd3, 4'd0, 4'd4, 16'd600);
        send(8'd255, 8'd255, 4'd0, 4'd5, 16'd65025);
        send(8'd1, 8'd1, 4'd0, 4'd6, 16'd1);
        idle();
        drain();

        // Broken arrays, including clamped VBL requests.
        send(8'd15, 8'd15, 4'd3, 4'd7, 16'd208);
        send(8'd15, 8'd15, 4'd15, 4'd8, 16'd0);
        send(8'd255, 8'd255, 4'd7, 4'd9, 16'd64256);
        send(8'd255, 8'd255, 4'd12, 4'd10, 16'd64256);
        send(8'd128, 8'd128, 4'd7, 4'd11, 16'd16384);
        send(8'd1, 8'd1, 4'd1, 4'd12, 16'd0);
        send(8'd255, 8'd1, 4'd4, 4'd13, 16'd240);
        idle();
        drain();

        // Back-to-back beats at full rate with mixed VBLs.
        max_run = 0;
        for (int n = 0; n < 16; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rv = 4'($urandom_range(0, 7));
            send(ra, rb, rv, 4'(n), model(ra, rb, rv));
        end
        idle();
        drain();
        check("full_rate_run", 32'(max_run >= 16), 32'd1);

        // Backpressure: three beats fill the pipe, the fourth waits, no bubble on release.
        out_ready = 1'b0;
        send(8'd1, 8'd1, 4'd0, 4'd1, 16'd1);
        send(8'd2, 8'd3, 4'd0, 4'd2, 16'd6);
        send(8'd255, 8'd255, 4'd0, 4'd3, 16'd65025);
        @(posedge clk);
        #1;
        in_a = 8'd255; in_b = 8'd255; in_vbl = 4'd7; in_tag = 4'd4;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_out_valid", 32'(out_valid), 32'd1);
            check("full_out_r", 32'(out_r), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("no_bubble_in_ready", 32'(in_ready), 32'd1);
        wait_accept({4'd4, 16'd64256});
        send(8'd128, 8'd128, 4'd7, 4'd5, 16'd16384);
        send(8'd255, 8'd1, 4'd4, 4'd6, 16'd240);
        idle();
        drain();

        // Random handshake toggling on both sides.
        pend = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    in_a     = 8'($urandom_range(0, 255));
                    in_b     = 8'($urandom_range(0, 255));
                    in_vbl   = 4'($urandom_range(0, 15));
                    in_tag   = 4'($urandom_range(0, 15));
                    in_valid = 1'b1;
                    pend     = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, model(in_a, in_b, in_vbl)});
                pend = 1'b0;
            end
        end
        idle();
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        send(8'd9, 8'd9, 4'd0, 4'd1, 16'd81);
        send(8'd10, 8'd10, 4'd0, 4'd2, 16'd100);
        send(8'd11, 8'd11, 4'd0, 4'd3, 16'd121);
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_r", 32'(out_r), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(8'd5, 8'd7, 4'd0, 4'd9, 16'd35);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
